// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, I-memory request, IF/ID latch.
// Three-state control (FETCH/STALL/HALTED) with redirect, hazard hold and halt.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_hold,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iren,
    output logic [31:0] iaddr,
    output logic [31:0] instr_IF,
    output logic [31:0] npc_IF,
    output logic        valid_IF,
    output logic        halt_IF,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {S_FETCH, S_STALL, S_HALTED} state_t;

    state_t      r_state, w_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic        r_valid;
    logic        r_halt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    logic        w_redir;
    logic        w_accept;
    logic        w_clr_valid;
    logic        w_stall_inc;
    logic [31:0] w_pc_plus4;
    logic        w_unused;

    // Redirect targets are word aligned; the low bits are dropped.
    assign w_unused   = ^redirect_pc[1:0];
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_FETCH;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_redir     = 1'b0;
        w_accept    = 1'b0;
        w_clr_valid = 1'b0;
        w_stall_inc = 1'b0;
        if (r_state != S_HALTED && redirect_valid) begin
            w_redir = 1'b1;
            w_nxt   = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (pc_hold) begin
                        w_nxt = S_STALL;
                    end else if (ihit) begin
                        w_accept = 1'b1;
                        if (iload[31:26] == HALT_OP) w_nxt = S_HALTED;
                    end else begin
                        w_clr_valid = 1'b1;
                    end
                end
                S_STALL: begin
                    if (pc_hold) w_stall_inc = 1'b1;
                    else         w_nxt = S_FETCH;
                end
                S_HALTED: w_clr_valid = 1'b1;
                default:  w_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc        <= PC_INIT;
            r_instr     <= '0;
            r_npc       <= '0;
            r_valid     <= 1'b0;
            r_halt      <= 1'b0;
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_redir) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_instr     <= iload;
                r_npc       <= w_pc_plus4;
                r_valid     <= 1'b1;
                r_pc        <= w_pc_plus4;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
                if (iload[31:26] == HALT_OP) r_halt <= 1'b1;
            end
            if (w_clr_valid) r_valid <= 1'b0;
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign iren      = (r_state == S_FETCH);
    assign iaddr     = r_pc;
    assign instr_IF  = r_instr;
    assign npc_IF    = r_npc;
    assign valid_IF  = r_valid;
    assign halt_IF   = r_halt;
    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model feeds a queue of expected
// post-edge snapshots, popped and compared after every clock.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST, pc_hold, redirect_valid, ihit;
    logic [31:0] redirect_pc, iload;
    logic        iren, valid_IF, halt_IF;
    logic [31:0] iaddr, instr_IF, npc_IF, fetch_cnt, stall_cnt;
    logic        u2_iren, u2_valid, u2_halt;
    logic [31:0] u2_iaddr, u2_instr, u2_npc, u2_fcnt, u2_scnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .pc_hold(pc_hold), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ihit(ihit), .iload(iload), .iren(iren),
        .iaddr(iaddr), .instr_IF(instr_IF), .npc_IF(npc_IF), .valid_IF(valid_IF),
        .halt_IF(halt_IF), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u2 (
        .CLK(CLK), .RST(RST), .pc_hold(pc_hold), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ihit(ihit), .iload(iload), .iren(u2_iren),
        .iaddr(u2_iaddr), .instr_IF(u2_instr), .npc_IF(u2_npc), .valid_IF(u2_valid),
        .halt_IF(u2_halt), .fetch_cnt(u2_fcnt), .stall_cnt(u2_scnt)
    );

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        halt;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb[$];

    // model state: 0 FETCH, 1 STALL, 2 HALTED
    int          m_st = 0;
    logic [31:0] m_pc = 0, m_instr = 0, m_npc = 0, m_fc = 0, m_sc = 0;
    logic        m_valid = 0, m_halt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, hold, rv, input logic [31:0] rpc,
                              input logic hit, input logic [31:0] ld);
        if (rst) begin
            m_st = 0; m_pc = 0; m_instr = 0; m_npc = 0;
            m_valid = 0; m_halt = 0; m_fc = 0; m_sc = 0;
        end else if (m_st != 2 && rv) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_valid = 0; m_st = 0;
        end else if (m_st == 2) begin
            m_valid = 0;
        end else if (hold) begin
            if (m_st == 0) m_st = 1;
            else           m_sc = m_sc + 1;
        end else if (m_st == 1) begin
            m_st = 0;
        end else if (hit) begin
            m_instr = ld; m_npc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            m_fc = m_fc + 1;
            if (ld[31:26] == 6'b111111) begin m_halt = 1; m_st = 2; end
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic cyc(input logic rst, hold, rv, input logic [31:0] rpc,
                       input logic hit, input logic [31:0] ld);
        exp_t e;
        RST = rst; pc_hold = hold; redirect_valid = rv;
        redirect_pc = rpc; ihit = hit; iload = ld;
        model_step(rst, hold, rv, rpc, hit, ld);
        e.iren = (m_st == 0); e.iaddr = m_pc; e.instr = m_instr; e.npc = m_npc;
        e.valid = m_valid; e.halt = m_halt; e.fcnt = m_fc; e.scnt = m_sc;
        sb.push_back(e);
        @(posedge CLK); #1;
        e = sb.pop_front();
        chk("iren",      {31'd0, iren},     {31'd0, e.iren});
        chk("iaddr",     iaddr,             e.iaddr);
        chk("instr_IF",  instr_IF,          e.instr);
        chk("npc_IF",    npc_IF,            e.npc);
        chk("valid_IF",  {31'd0, valid_IF}, {31'd0, e.valid});
        chk("halt_IF",   {31'd0, halt_IF},  {31'd0, e.halt});
        chk("fetch_cnt", fetch_cnt,         e.fcnt);
        chk("stall_cnt", stall_cnt,         e.scnt);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] tagw(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    initial begin
        RST = 0; pc_hold = 0; redirect_valid = 0; redirect_pc = 0; ihit = 0; iload = 0;
        @(negedge CLK);

        // reset, including override of concurrent activity
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h40, 1, 32'h1234_5678);
        chk("rst_iaddr_first", iaddr, 32'h0);
        chk("u2_rst_iaddr", u2_iaddr, 32'hFFFF_FFFC);

        // streaming fetch, wrap on the high-PC instance after first accept
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, tagw(m_pc));
            if (i == 0) begin
                chk("u2_wrap_npc",   u2_npc,   32'h0);
                chk("u2_wrap_iaddr", u2_iaddr, 32'h0);
            end
        end
        chk("stream_fcnt", fetch_cnt, 32'd4);
        chk("stream_instr", instr_IF, 32'h1000_000C);
        cyc(0, 0, 0, 0, 0, 0);

        // hold for 3 cycles at PC=8 with ihit asserted
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, tagw(m_pc));
        cyc(0, 0, 0, 0, 1, tagw(m_pc));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 32'h2222_2222);
        chk("hold_scnt", stall_cnt, 32'd2);
        chk("hold_iren", {31'd0, iren}, 32'd0);
        chk("hold_instr", instr_IF, 32'h1000_0004);
        cyc(0, 0, 0, 0, 1, 32'h3333_3333);
        chk("rerequest_iaddr", iaddr, 32'h8);
        chk("rerequest_iren", {31'd0, iren}, 32'd1);
        cyc(0, 0, 0, 0, 1, tagw(m_pc));

        // redirect beats hold and ihit
        cyc(0, 1, 1, 32'h0000_0103, 1, 32'h4444_4444);
        chk("redir_valid", {31'd0, valid_IF}, 32'd0);
        chk("redir_iaddr", iaddr, 32'h0000_0100);
        cyc(0, 0, 0, 0, 1, tagw(m_pc));
        // redirect out of STALL
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_0202, 0, 0);
        chk("redir_stall_iaddr", iaddr, 32'h0000_0200);

        // halt at PC=C
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, tagw(m_pc));
        cyc(0, 0, 0, 0, 1, 32'hFC00_0000);
        chk("halt_set", {31'd0, halt_IF}, 32'd1);
        chk("halt_npc", npc_IF, 32'h10);
        cyc(0, 0, 1, 32'h0000_0300, 1, tagw(32'h300));
        cyc(0, 1, 1, 32'h0000_0400, 1, tagw(32'h400));
        chk("halt_fcnt", fetch_cnt, 32'd4);
        chk("halt_iaddr", iaddr, 32'h10);
        // reset while halted
        cyc(1, 0, 1, 32'h500, 1, 0);
        chk("rst_halt_iaddr", iaddr, 32'h0);

        // reset while stalled
        cyc(0, 0, 0, 0, 1, tagw(m_pc));
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0);
        chk("rst_stall_iren", {31'd0, iren}, 32'd1);

        // random mix
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ld, rp;
            ld = $urandom;
            rp = $urandom_range(0, 32'hFFFF);
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), rp, ($urandom_range(0, 3) != 0), ld);
        end

        if (sb.size() != 0) chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter HALT_OP, default 6'b111111, is the opcode that halts fetch.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 pc_hold  input  1  hazard-unit stall request; 1 = freeze PC and IF/ID outputs.
REQ-006 redirect_valid  input  1  jump/JR/JAL resolved in MEM; take redirect_pc.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 2'b00).
REQ-008 ihit  input  1  instruction memory has returned data for iaddr this cycle.
REQ-009 iload  input  32  instruction word; valid only when ihit=1.
REQ-010 iren  output  1  instruction memory read request.
REQ-011 iaddr  output  32  read address; always equals the current PC.
REQ-012 instr_IF  output  32  registered fetched instruction to IF/ID.
REQ-013 npc_IF  output  32  registered PC+4 of instr_IF.
REQ-014 valid_IF  output  1  registered; 1 = instr_IF/npc_IF hold a live instruction.
REQ-015 halt_IF  output  1  registered; 1 once a HALT_OP word has been accepted.
REQ-016 fetch_cnt  output  32  count of accepted instructions.
REQ-017 stall_cnt  output  32  count of cycles in state STALL.

Function
REQ-018 State machine SHALL have exactly three states: FETCH, STALL, HALTED.
REQ-019 iren SHALL be 1 in FETCH only; 0 in STALL and HALTED.
REQ-020 Priority each cycle SHALL be: RST > redirect_valid > pc_hold > ihit.
REQ-021 Redirect, any state except HALTED: PC <= {redirect_pc[31:2],2'b00}, valid_IF <= 0, any same-cycle ihit data discarded, next state FETCH.
REQ-022 FETCH, pc_hold=1, no redirect: PC, instr_IF, npc_IF, valid_IF held; ihit ignored; next state STALL.
REQ-023 STALL, pc_hold=1: all registers held; stall_cnt += 1; stay STALL.
REQ-024 STALL, pc_hold=0: registers held; next state FETCH, so the same address is requested again.
REQ-025 FETCH, ihit=1, no hold or redirect: instr_IF <= iload, npc_IF <= PC+4, valid_IF <= 1, PC <= PC+4, fetch_cnt += 1 (an accept).
REQ-026 FETCH, ihit=0, no hold or redirect: valid_IF <= 0, PC held, stay FETCH.
REQ-027 Accept of a word with iload[31:26]=HALT_OP SHALL additionally set halt_IF <= 1 and enter HALTED; PC is still advanced.
REQ-028 HALTED SHALL be left only by RST. In HALTED, the cycle after entry SHALL clear valid_IF; redirect, pc_hold and ihit are ignored.
REQ-029 Fetch latency SHALL be 1 cycle: the instruction appears on instr_IF the cycle after the ihit that is accepted.
REQ-030 PC and npc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-031 fetch_cnt and stall_cnt SHALL be 32-bit and wrap to 0.

Reset
REQ-032 RST=1 SHALL give the following values on the next edge: PC=PC_INIT, state=FETCH, instr_IF=0, npc_IF=0, valid_IF=0, halt_IF=0, fetch_cnt=0, stall_cnt=0.
REQ-033 RST SHALL override a same-cycle redirect, hold or ihit. It also aborts any STALL or HALTED state.
REQ-034 The first cycle after reset release SHALL present iren=1 and iaddr=PC_INIT.

Verification
REQ-035 Stimulus: reset, then ihit=1 every cycle with iload=addr-tagged words, for 4 cycles. Required: iaddr = 0,4,8,C; instr_IF follows one cycle later; fetch_cnt=4.
REQ-036 Stimulus: pc_hold=1 for 3 cycles starting at PC=8, with ihit=1 throughout. Required: iren=0 for cycles 2-3; instr_IF and valid_IF frozen; stall_cnt=2; iaddr=8 re-requested after release.
REQ-037 Stimulus: redirect_valid=1 with redirect_pc=32'h0000_0103, concurrent with ihit and pc_hold. Required: valid_IF=0 next cycle; iaddr=32'h0000_0100; state FETCH.
REQ-038 Stimulus: accept iload=32'hFC00_0000 at PC=C. Required: halt_IF=1; iren=0 thereafter; a later redirect is ignored; fetch_cnt frozen.
REQ-039 Stimulus: RST asserted while in STALL, and separately while HALTED. Required: all REQ-032 values; iaddr=PC_INIT on the next cycle.
REQ-040 Stimulus: PC_INIT=32'hFFFF_FFFC, accept one word. Required: npc_IF=0 and iaddr=0.
